// File: rtl/counter_cmd_pkg.sv
// Shared types for the counter command controller: FSM states, command codes, counter width.
// The REPEAT state exists only when COUNTER_CMD_AUTO_REPEAT_EN is defined.
package counter_cmd_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_REL
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
        , ST_REPEAT
`endif
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_UP,
        CMD_DOWN,
        CMD_LOAD
    } cmd_e;

    // Load beats up beats down; up and down together without load cancel out.
    function automatic cmd_e decode_btn(input logic up, input logic down, input logic ld);
        cmd_e c;
        c = CMD_NONE;
        if (ld)
            c = CMD_LOAD;
        else if (up && !down)
            c = CMD_UP;
        else if (down && !up)
            c = CMD_DOWN;
        return c;
    endfunction

    function automatic logic at_limit(input cmd_e c, input logic [CNT_W-1:0] q);
        return ((c == CMD_UP) && (q == CNT_MAX)) || ((c == CMD_DOWN) && (q == '0));
    endfunction

endpackage

// File: rtl/counter_cmd_repeat_timer.sv
// Hold/repeat down-counter: load wins over decrement, decrement stops at zero.
module repeat_timer #(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Button-to-command controller for an up/down/load counter; one pulse per press.
// Optional auto-repeat of held up/down buttons is enabled by COUNTER_CMD_AUTO_REPEAT_EN.
module counter_cmd_ctrl
    import counter_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int SATURATE      = 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] Q_IN,
    output logic             increase,
    output logic             decrease,
    output logic             parallel,
    output logic [CNT_W-1:0] load,
    output logic             busy
);

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic             inc_q, inc_d, dec_q, dec_d, par_q, par_d, busy_q, busy_d;
    logic [CNT_W-1:0] load_q, load_d;

    cmd_e btn_cmd;
    logic any_btn, sat_btn;

    assign btn_cmd = decode_btn(btn_up, btn_down, btn_load);
    assign any_btn = btn_up | btn_down | btn_load;
    assign sat_btn = (SATURATE != 0) && at_limit(btn_cmd, Q_IN);

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             held_alone, sat_cur;

    // The accepted up/down button must be the only one held for the hold/repeat timing to count.
    assign held_alone = ((cmd_q == CMD_UP) || (cmd_q == CMD_DOWN)) && (btn_cmd == cmd_q);
    assign sat_cur    = (SATURATE != 0) && at_limit(cmd_q, Q_IN);

    repeat_timer #(.W(TMR_W)) u_repeat_timer (
        .CLK      (CLK),
        .CLR      (CLR),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        par_d   = 1'b0;
        load_d  = load_q;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = TMR_W'(HOLD_CYCLES - 1);
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_btn) begin
                    cmd_d   = btn_cmd;
                    state_d = (btn_cmd == CMD_NONE) ? ST_WAIT_REL : ST_ISSUE;
                    inc_d   = (btn_cmd == CMD_UP) && !sat_btn;
                    dec_d   = (btn_cmd == CMD_DOWN) && !sat_btn;
                    par_d   = (btn_cmd == CMD_LOAD);
                    if (btn_cmd == CMD_LOAD)
                        load_d = load_val;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
                    tmr_load = (btn_cmd == CMD_UP) || (btn_cmd == CMD_DOWN);
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_REL;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
                tmr_dec = 1'b1;
`endif
            end
            ST_WAIT_REL: begin
                if (!any_btn)
                    state_d = ST_IDLE;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
                else if (!held_alone)
                    cmd_d = CMD_NONE;
                else if (tmr_zero) begin
                    state_d  = ST_REPEAT;
                    inc_d    = (cmd_q == CMD_UP) && !sat_cur;
                    dec_d    = (cmd_q == CMD_DOWN) && !sat_cur;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REPEAT_CYCLES - 1);
                end else
                    tmr_dec = 1'b1;
`endif
            end
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (!held_alone) begin
                    state_d = ST_WAIT_REL;
                    cmd_d   = CMD_NONE;
                end else if (tmr_zero) begin
                    inc_d    = (cmd_q == CMD_UP) && !sat_cur;
                    dec_d    = (cmd_q == CMD_DOWN) && !sat_cur;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REPEAT_CYCLES - 1);
                end else
                    tmr_dec = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            par_q   <= 1'b0;
            load_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            par_q   <= par_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    assign increase = inc_q;
    assign decrease = dec_q;
    assign parallel = par_q;
    assign load     = load_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Bench for counter_cmd_ctrl: a saturating and a wrapping instance share all inputs.
module tb_counter_cmd_ctrl;

    localparam int HOLD = 16;
    localparam int REP  = 4;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
    logic [3:0] load_val = 4'd0, q_in = 4'd0;

    logic       inc_s, dec_s, par_s, busy_s;
    logic       inc_w, dec_w, par_w, busy_w;
    logic [3:0] load_s, load_w;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    counter_cmd_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SATURATE(1)) u_sat (
        .CLK(CLK), .CLR(CLR), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .load_val(load_val), .Q_IN(q_in), .increase(inc_s), .decrease(dec_s),
        .parallel(par_s), .load(load_s), .busy(busy_s)
    );

    counter_cmd_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .SATURATE(0)) u_wrap (
        .CLK(CLK), .CLR(CLR), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .load_val(load_val), .Q_IN(q_in), .increase(inc_w), .decrease(dec_w),
        .parallel(par_w), .load(load_w), .busy(busy_w)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({inc_s, dec_s, par_s, busy_s, load_s, inc_w, dec_w, par_w, busy_w, load_w} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got sat=%b%b%b%b/%h wrap=%b%b%b%b/%h exp all 0",
                     inc_s, dec_s, par_s, busy_s, load_s, inc_w, dec_w, par_w, busy_w, load_w);
        end
        btn_up = 1'b1; btn_load = 1'b1; load_val = 4'd7;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, load_s} !== 8'h0) begin
                errors++;
                $display("FAIL reset_held cyc %0d got %b%b%b%b/%h exp 0", c, inc_s, dec_s, par_s, busy_s, load_s);
            end
        end
        btn_up = 1'b0; btn_load = 1'b0;
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    // Up held 3 cycles: one pulse in the cycle after acceptance, busy drops one edge after release.
    task automatic test_up_hold;
        logic [3:0] exp;
        q_in = 4'd5;
        btn_up = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) btn_up = 1'b0;
            tick;
            exp = (c == 1) ? 4'b1001 : (c == 4) ? 4'b0000 : 4'b0001;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w} !== {exp, exp}) begin
                errors++;
                $display("FAIL up_hold cyc %0d got %b%b%b%b/%b%b%b%b exp %b", c,
                         inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w, exp);
            end
        end
    endtask

    task automatic test_load_priority;
        logic [3:0] exp;
        load_val = 4'd9;
        btn_load = 1'b1; btn_up = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 1) begin
                btn_load = 1'b0; btn_up = 1'b0; load_val = 4'd3;
            end
            exp = (c == 1) ? 4'b0011 : (c == 2) ? 4'b0001 : 4'b0000;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w} !== {exp, exp}
                || load_s !== 4'd9 || load_w !== 4'd9) begin
                errors++;
                $display("FAIL load_prio cyc %0d got %b%b%b%b load %0d/%0d exp %b load 9", c,
                         inc_s, dec_s, par_s, busy_s, load_s, load_w, exp);
            end
        end
    endtask

    task automatic test_saturation;
        // Down at 0, up at 15, up at 0: only the saturating instance suppresses the limit cases.
        logic [3:0] qv [3];
        logic       up_sel [3];
        qv[0] = 4'd0;  up_sel[0] = 1'b0;
        qv[1] = 4'd15; up_sel[1] = 1'b1;
        qv[2] = 4'd0;  up_sel[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            q_in = qv[t];
            btn_up = up_sel[t]; btn_down = !up_sel[t];
            tick;
            btn_up = 1'b0; btn_down = 1'b0;
            checks++;
            if (inc_w !== up_sel[t] || dec_w !== !up_sel[t] || busy_w !== 1'b1) begin
                errors++;
                $display("FAIL sat_wrap case %0d got inc %b dec %b busy %b exp inc %b dec %b busy 1",
                         t, inc_w, dec_w, busy_w, up_sel[t], !up_sel[t]);
            end
            checks++;
            if (inc_s !== (t == 2) || dec_s !== 1'b0 || busy_s !== 1'b1) begin
                errors++;
                $display("FAIL sat_block case %0d got inc %b dec %b busy %b exp inc %b dec 0 busy 1",
                         t, inc_s, dec_s, busy_s, (t == 2));
            end
            tick;
            tick;
            checks++;
            if (busy_s !== 1'b0 || busy_w !== 1'b0) begin
                errors++;
                $display("FAIL sat_idle case %0d got busy %b/%b exp 0", t, busy_s, busy_w);
            end
        end
    endtask

    task automatic test_up_down;
        logic [3:0] exp;
        q_in = 4'd7;
        btn_up = 1'b1; btn_down = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            if (c == 5) btn_down = 1'b0;
            if (c == 6) btn_up = 1'b0;
            tick;
            exp = (c == 6) ? 4'b0000 : 4'b0001;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w} !== {exp, exp}) begin
                errors++;
                $display("FAIL up_down cyc %0d got %b%b%b%b/%b%b%b%b exp %b", c,
                         inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w, exp);
            end
        end
    endtask

    task automatic test_clr_mid_issue;
        q_in = 4'd5;
        btn_up = 1'b1;
        tick;
        checks++;
        if (inc_s !== 1'b1 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre got inc %b busy %b exp 1 1", inc_s, busy_s);
        end
        #1;
        CLR = 1'b1;
        btn_up = 1'b0;
        #1;
        checks++;
        if ({inc_s, dec_s, par_s, busy_s, load_s, inc_w, dec_w, par_w, busy_w, load_w} !== 16'h0) begin
            errors++;
            $display("FAIL clr_async got sat=%b%b%b%b/%h wrap=%b%b%b%b/%h exp all 0",
                     inc_s, dec_s, par_s, busy_s, load_s, inc_w, dec_w, par_w, busy_w, load_w);
        end
        @(negedge CLK);
        CLR = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w} !== 8'h0) begin
                errors++;
                $display("FAIL clr_after cyc %0d got %b%b%b%b/%b%b%b%b exp 0", c,
                         inc_s, dec_s, par_s, busy_s, inc_w, dec_w, par_w, busy_w);
            end
        end
    endtask

    // Reference: an idle controller takes one press, then ignores buttons until it sees them all low.
    task automatic test_random;
        bit       m_busy = 1'b0;
        int       m_since = 0;
        int       m_minrel = 2;
        bit [3:0] m_load = 4'd0;
        bit       e_inc_s, e_inc_w, e_dec_s, e_dec_w, e_par;
        int       r;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            if (r < 7) {btn_up, btn_down, btn_load} = 3'b000;
            else {btn_up, btn_down, btn_load} = 3'($urandom_range(1, 7));
            load_val = 4'($urandom);
            r = $urandom_range(0, 9);
            q_in = (r < 3) ? 4'd0 : (r < 6) ? 4'd15 : 4'($urandom);
            {e_inc_s, e_inc_w, e_dec_s, e_dec_w, e_par} = '0;
            if (!m_busy) begin
                if (btn_up || btn_down || btn_load) begin
                    m_busy = 1'b1;
                    m_since = 0;
                    m_minrel = 2;
                    if (btn_load) begin
                        e_par = 1'b1;
                        m_load = load_val;
                    end else if (btn_up && btn_down)
                        m_minrel = 1;
                    else if (btn_up) begin
                        e_inc_w = 1'b1;
                        e_inc_s = (q_in != 4'd15);
                    end else begin
                        e_dec_w = 1'b1;
                        e_dec_s = (q_in != 4'd0);
                    end
                end
            end else begin
                m_since++;
                if (m_since >= m_minrel && !(btn_up || btn_down || btn_load))
                    m_busy = 1'b0;
            end
            tick;
            checks++;
            if ({inc_s, dec_s, par_s, busy_s, load_s} !== {e_inc_s, e_dec_s, e_par, m_busy, m_load}) begin
                errors++;
                $display("FAIL rand_sat n %0d got %b%b%b%b/%h exp %b%b%b%b/%h", n,
                         inc_s, dec_s, par_s, busy_s, load_s, e_inc_s, e_dec_s, e_par, m_busy, m_load);
            end
            checks++;
            if ({inc_w, dec_w, par_w, busy_w, load_w} !== {e_inc_w, e_dec_w, e_par, m_busy, m_load}) begin
                errors++;
                $display("FAIL rand_wrap n %0d got %b%b%b%b/%h exp %b%b%b%b/%h", n,
                         inc_w, dec_w, par_w, busy_w, load_w, e_inc_w, e_dec_w, e_par, m_busy, m_load);
            end
        end
        {btn_up, btn_down, btn_load} = 3'b000;
        tick;
        tick;
        tick;
    endtask

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
    task automatic test_auto_repeat;
        bit e_dec;
        q_in = 4'd10;
        btn_down = 1'b1;
        for (int n = 1; n <= 42; n++) begin
            if (n == 41) btn_down = 1'b0;
            tick;
            e_dec = (n == 1) || (n >= 1 + HOLD && n <= 40 && ((n - 1 - HOLD) % REP) == 0);
            checks++;
            if ({inc_s, dec_s, par_s, busy_s} !== {1'b0, e_dec, 1'b0, (n != 42)}
                || dec_w !== e_dec) begin
                errors++;
                $display("FAIL auto_rep cyc %0d got %b%b%b%b dec_w %b exp dec %b busy %b", n,
                         inc_s, dec_s, par_s, busy_s, dec_w, e_dec, (n != 42));
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_up_hold;
        test_load_priority;
        test_saturation;
        test_up_down;
        test_clr_mid_issue;
        test_random;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
        test_auto_repeat;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_cmd_ctrl.md
COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles a button is held before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 4: cycles between auto-repeat pulses.
REQ-003 SHALL have parameter SATURATE, default 1: 1 suppresses increase at count 15 and decrease at count 0.
REQ-004 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port CLR  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port btn_up  input  1  request count up (level, already synchronised).
REQ-007 SHALL have port btn_down  input  1  request count down (level).
REQ-008 SHALL have port btn_load  input  1  request parallel load (level).
REQ-009 SHALL have port load_val  input  4  value to load.
REQ-010 SHALL have port Q_IN  input  4  current counter value, fed back from the counter.
REQ-011 SHALL have port increase  output  1  one-cycle count-up command.
REQ-012 SHALL have port decrease  output  1  one-cycle count-down command.
REQ-013 SHALL have port parallel  output  1  one-cycle load command.
REQ-014 SHALL have port load  output  4  load value, registered.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT_REL, and REPEAT (REPEAT exists only with the macro).
REQ-017 SHALL, in IDLE, accept the highest-priority asserted button: load first, then up, then down; the accepted command is registered and the FSM moves to ISSUE.
REQ-018 SHALL treat btn_up and btn_down both high with btn_load low as no command, and move directly to WAIT_REL.
REQ-019 SHALL assert exactly one command output for exactly one cycle in ISSUE, the cycle after acceptance: latency 1.
REQ-020 SHALL register load_val into load at acceptance of a load command and hold it until the next accepted load.
REQ-021 SHALL never assert more than one of increase, decrease, and parallel in the same cycle.
REQ-022 SHALL, with SATURATE=1, suppress the pulse when increase is requested at Q_IN=15 or decrease at Q_IN=0; the FSM still passes through ISSUE.
REQ-023 SHALL, with SATURATE=0, pass increase and decrease through unconditionally, letting the counter wrap 15->0 and 0->15.
REQ-024 SHALL move from ISSUE to WAIT_REL, and stay in WAIT_REL until all three buttons are low, then return to IDLE on the next edge.
REQ-025 SHALL not re-accept a button that stays held without AUTO_REPEAT_EN: one press gives one pulse.

Reset
REQ-026 SHALL, while CLR=1 and independent of CLK, force state=IDLE, increase=0, decrease=0, parallel=0, load=0, busy=0, and repeat timer=0.
REQ-027 SHALL abandon any command in flight when CLR is asserted mid-operation; no pulse is emitted after CLR deasserts until a fresh press is seen in IDLE.

Configuration
REQ-028 SHALL use macro COUNTER_CMD_AUTO_REPEAT_EN.
REQ-029 SHALL, when the macro is defined: move WAIT_REL to REPEAT once the same up/down button has been held alone for HOLD_CYCLES; then emit one pulse every REPEAT_CYCLES while held (SATURATE applies); leave REPEAT for WAIT_REL when the button changes or is released.
REQ-030 SHALL never auto-repeat a load command.
REQ-031 SHALL, when the macro is undefined, contain no repeat timer or REPEAT state, so that REQ-025 holds.

Structure
REQ-032 SHALL place the state enum, the command enum (NONE/UP/DOWN/LOAD), and the width constant (4) in package counter_cmd_pkg.
REQ-033 SHALL implement the hold/repeat down-counter as sub-module repeat_timer (load, decrement, zero flag), instantiated only under the macro.

Verification
REQ-034 SHALL cover: CLR pulse mid-ISSUE -> all outputs 0 immediately, busy=0, no pulse afterward.
REQ-035 SHALL cover: btn_up high 3 cycles, Q_IN=5 -> increase high exactly 1 cycle, 1 cycle after the rising edge; busy returns low 1 cycle after release.
REQ-036 SHALL cover: btn_load+btn_up together, load_val=9 -> parallel pulse only, load=9 held afterward.
REQ-037 SHALL cover: SATURATE=1, Q_IN=0, btn_down press -> no decrease pulse; with SATURATE=0 -> decrease pulse.
REQ-038 SHALL cover: btn_up+btn_down together -> no command output; busy stays high until both are released.
REQ-039 SHALL cover: with the macro, btn_down held 40 cycles, Q_IN=10 -> pulses at cycles 1, 17, 21, 25, ... while held.
